// File: rtl/led_pattern_sequencer_pkg.sv
// rtl/led_pattern_sequencer_pkg.sv - shared mode/state types, pattern seeds and pattern helpers
package led_pattern_sequencer_pkg;

  typedef enum logic [1:0] {
    ROT_L  = 2'd0,
    ROT_R  = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic [3:0] SEED_ROT_L  = 4'b1000;
  localparam logic [3:0] SEED_ROT_R  = 4'b0001;
  localparam logic [3:0] SEED_BOUNCE = 4'b1000;
  localparam logic [3:0] SEED_BLINK  = 4'b1111;

  localparam logic DIR_TO_LED4 = 1'b0;
  localparam logic DIR_TO_LED1 = 1'b1;

  function automatic logic [3:0] mode_seed(mode_e m);
    case (m)
      ROT_L:   return SEED_ROT_L;
      ROT_R:   return SEED_ROT_R;
      BOUNCE:  return SEED_BOUNCE;
      default: return SEED_BLINK;
    endcase
  endfunction

  function automatic logic is_one_hot(logic [3:0] p);
    return (p != 4'b0000) && ((p & (p - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// rtl/led_pattern_sequencer_if.sv - board-side button inputs and LED/status outputs
interface led_pattern_sequencer_if;
  import led_pattern_sequencer_pkg::*;

  logic       sw_mode_i;
  logic       sw_run_i;
  logic [3:0] led_o;
  mode_e      mode_o;
  logic       running_o;

  modport master (
    output sw_mode_i, sw_run_i,
    input  led_o, mode_o, running_o
  );

  modport slave (
    input  sw_mode_i, sw_run_i,
    output led_o, mode_o, running_o
  );

endinterface

// File: rtl/led_pattern_sequencer_button_press_filter.sv
// rtl/led_pattern_sequencer_button_press_filter.sv - synchronizer, debounce and press-pulse for one raw button
module button_press_filter #(
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic             level_prev_q;
  logic [CNT_W-1:0] cnt_q;

  // The filtered level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q       <= 2'b00;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
      press        <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], raw};
      level_prev_q <= level_q;
      press        <= level_q & ~level_prev_q;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - run/pause FSM, mode, step tick and 4-LED pattern register
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int TICK_DIV        = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  led_pattern_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(TICK_DIV);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [3:0]       led_q, led_d, step_pat;
  logic             dir_q, dir_d, step_dir;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick, mode_press, run_press;

  button_press_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_filter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .raw    (bus.sw_mode_i),
    .press  (mode_press)
  );

  button_press_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_filter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .raw    (bus.sw_run_i),
    .press  (run_press)
  );

  assign tick = (state_q == RUN) && (cnt_q == CNT_W'(TICK_DIV - 1));

  // Next pattern for one step; a corrupted (non one-hot) shift pattern falls back to the seed.
  always_comb begin
    step_pat = led_q;
    step_dir = dir_q;
    case (mode_q)
      ROT_L: step_pat = is_one_hot(led_q) ? {led_q[0], led_q[3:1]} : SEED_ROT_L;
      ROT_R: step_pat = is_one_hot(led_q) ? {led_q[2:0], led_q[3]} : SEED_ROT_R;
      BOUNCE: begin
        if (!is_one_hot(led_q)) begin
          step_pat = SEED_BOUNCE;
          step_dir = DIR_TO_LED4;
        end else if (dir_q == DIR_TO_LED4) begin
          step_pat = led_q[0] ? 4'b0010 : (led_q >> 1);
          step_dir = (led_q[1] || led_q[0]) ? DIR_TO_LED1 : DIR_TO_LED4;
        end else begin
          step_pat = led_q[3] ? 4'b0100 : (led_q << 1);
          step_dir = (led_q[2] || led_q[3]) ? DIR_TO_LED4 : DIR_TO_LED1;
        end
      end
      default: step_pat = (led_q == SEED_BLINK) ? 4'b0000 : SEED_BLINK;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mode_q  <= ROT_L;
      led_q   <= 4'b0000;
      dir_q   <= DIR_TO_LED4;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority: tick step, then mode press overrides it, then the run transition.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    led_d   = led_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;

    if (state_q == RUN) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end else if (state_q == IDLE) begin
      cnt_d = '0;
    end

    if (tick) begin
      led_d = step_pat;
      dir_d = step_dir;
    end

    if (mode_press) begin
      mode_d = mode_e'(mode_q + 2'd1);
      dir_d  = DIR_TO_LED4;
      cnt_d  = '0;
      if (state_q != IDLE) begin
        led_d = mode_seed(mode_d);
      end
    end

    if (run_press) begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          led_d   = mode_seed(mode_d);
          dir_d   = DIR_TO_LED4;
          cnt_d   = '0;
        end
        RUN: begin
          state_d = PAUSE;
          if (!mode_press) begin
            led_d = led_q;
            dir_d = dir_q;
            cnt_d = cnt_q;
          end
        end
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.led_o     = led_q;
  assign bus.mode_o    = mode_q;
  assign bus.running_o = (state_q == RUN);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - directed self-checking bench for led_pattern_sequencer
module tb_led_pattern_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  led_pattern_sequencer_if bus ();

  led_pattern_sequencer #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_run();
    bus.sw_run_i = 1'b1;
    step(7);
    bus.sw_run_i = 1'b0;
  endtask

  task automatic press_mode();
    bus.sw_mode_i = 1'b1;
    step(7);
    bus.sw_mode_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.sw_mode_i = 1'b0;
    bus.sw_run_i  = 1'b0;
    rst_n = 1'b0;
    step(3);
    checks++;
    if ({bus.led_o, 2'(bus.mode_o), bus.running_o} !== 7'b0000_00_0) begin
      $display("FAIL reset_hold: got led=%b mode=%0d run=%b, expected 0000/0/0", bus.led_o, bus.mode_o, bus.running_o);
      errors++;
    end
    #4 rst_n = 1'b1;
    step(1);
    for (int i = 0; i < 50; i++) begin
      step(1);
      checks++;
      if ({bus.led_o, 2'(bus.mode_o), bus.running_o} !== 7'b0000_00_0) begin
        $display("FAIL idle_quiet cycle %0d: got led=%b mode=%0d run=%b, expected 0000/0/0", i, bus.led_o, bus.mode_o, bus.running_o);
        errors++;
      end
    end
  endtask

  task automatic test_glitch();
    bus.sw_run_i = 1'b1;
    step(2);
    bus.sw_run_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      checks++;
      if (bus.running_o !== 1'b0 || bus.led_o !== 4'b0000) begin
        $display("FAIL glitch_rejected cycle %0d: got run=%b led=%b, expected 0/0000", i, bus.running_o, bus.led_o);
        errors++;
      end
    end
  endtask

  task automatic test_start_run();
    bus.sw_run_i = 1'b1;
    step(6);
    checks++;
    if (bus.running_o !== 1'b0) begin
      $display("FAIL run_latency_early: got run=%b, expected 0", bus.running_o);
      errors++;
    end
    step(1);
    checks++;
    if (bus.running_o !== 1'b1 || bus.led_o !== 4'b1000 || bus.mode_o !== 2'd0) begin
      $display("FAIL run_start: got run=%b led=%b mode=%0d, expected 1/1000/0", bus.running_o, bus.led_o, bus.mode_o);
      errors++;
    end
    step(3);
    bus.sw_run_i = 1'b0;
    checks++;
    if (bus.led_o !== 4'b1000) begin
      $display("FAIL seed_hold: got led=%b, expected 1000", bus.led_o);
      errors++;
    end
  endtask

  task automatic test_rot_l();
    logic [3:0] exp_seq [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    step(1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(4);
      checks++;
      if (bus.led_o !== exp_seq[i]) begin
        $display("FAIL rot_l_step %0d: got led=%b, expected %b", i, bus.led_o, exp_seq[i]);
        errors++;
      end
    end
  endtask

  task automatic test_pause_resume();
    press_run();
    checks++;
    if (bus.running_o !== 1'b0 || bus.led_o !== 4'b0100) begin
      $display("FAIL pause_enter: got run=%b led=%b, expected 0/0100", bus.running_o, bus.led_o);
      errors++;
    end
    for (int i = 0; i < 40; i++) begin
      step(1);
      checks++;
      if (bus.running_o !== 1'b0 || bus.led_o !== 4'b0100) begin
        $display("FAIL pause_frozen cycle %0d: got run=%b led=%b, expected 0/0100", i, bus.running_o, bus.led_o);
        errors++;
      end
    end
    press_run();
    checks++;
    if (bus.running_o !== 1'b1 || bus.led_o !== 4'b0100) begin
      $display("FAIL resume_no_reload: got run=%b led=%b, expected 1/0100", bus.running_o, bus.led_o);
      errors++;
    end
    step(1);
    checks++;
    if (bus.led_o !== 4'b0100) begin
      $display("FAIL resume_count_held: got led=%b, expected 0100", bus.led_o);
      errors++;
    end
    step(1);
    checks++;
    if (bus.led_o !== 4'b0010) begin
      $display("FAIL resume_first_step: got led=%b, expected 0010", bus.led_o);
      errors++;
    end
  endtask

  task automatic test_mode_in_run();
    press_mode();
    checks++;
    if (bus.mode_o !== 2'd1 || bus.led_o !== 4'b0001 || bus.running_o !== 1'b1) begin
      $display("FAIL mode_rot_r_seed: got mode=%0d led=%b run=%b, expected 1/0001/1", bus.mode_o, bus.led_o, bus.running_o);
      errors++;
    end
    step(4);
    checks++;
    if (bus.led_o !== 4'b0010) begin
      $display("FAIL rot_r_step: got led=%b, expected 0010", bus.led_o);
      errors++;
    end
    step(2);
    press_mode();
    checks++;
    if (bus.mode_o !== 2'd2 || bus.led_o !== 4'b1000 || bus.running_o !== 1'b1) begin
      $display("FAIL mode_bounce_seed: got mode=%0d led=%b run=%b, expected 2/1000/1", bus.mode_o, bus.led_o, bus.running_o);
      errors++;
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_seq [7] = '{4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
    for (int i = 0; i < 7; i++) begin
      step(4);
      checks++;
      if (bus.led_o !== exp_seq[i]) begin
        $display("FAIL bounce_step %0d: got led=%b, expected %b", i, bus.led_o, exp_seq[i]);
        errors++;
      end
    end
  endtask

  task automatic test_tick_mode_collision();
    step(1);
    press_mode();
    checks++;
    if (bus.mode_o !== 2'd3 || bus.led_o !== 4'b1111) begin
      $display("FAIL tick_mode_collision: got mode=%0d led=%b, expected 3/1111", bus.mode_o, bus.led_o);
      errors++;
    end
    step(3);
    checks++;
    if (bus.led_o !== 4'b1111) begin
      $display("FAIL blink_hold: got led=%b, expected 1111", bus.led_o);
      errors++;
    end
    step(1);
    checks++;
    if (bus.led_o !== 4'b0000) begin
      $display("FAIL blink_toggle: got led=%b, expected 0000", bus.led_o);
      errors++;
    end
    step(2);
    press_mode();
    checks++;
    if (bus.mode_o !== 2'd0 || bus.led_o !== 4'b1000 || bus.running_o !== 1'b1) begin
      $display("FAIL mode_wrap: got mode=%0d led=%b run=%b, expected 0/1000/1", bus.mode_o, bus.led_o, bus.running_o);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    step(2);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.led_o, 2'(bus.mode_o), bus.running_o} !== 7'b0000_00_0) begin
      $display("FAIL async_reset: got led=%b mode=%0d run=%b, expected 0000/0/0", bus.led_o, bus.mode_o, bus.running_o);
      errors++;
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if ({bus.led_o, 2'(bus.mode_o), bus.running_o} !== 7'b0000_00_0) begin
        $display("FAIL post_reset_idle cycle %0d: got led=%b mode=%0d run=%b, expected 0000/0/0", i, bus.led_o, bus.mode_o, bus.running_o);
        errors++;
      end
    end
  endtask

  task automatic test_simultaneous_idle();
    bus.sw_mode_i = 1'b1;
    bus.sw_run_i  = 1'b1;
    step(7);
    bus.sw_mode_i = 1'b0;
    bus.sw_run_i  = 1'b0;
    checks++;
    if (bus.mode_o !== 2'd1 || bus.led_o !== 4'b0001 || bus.running_o !== 1'b1) begin
      $display("FAIL mode_run_same_cycle: got mode=%0d led=%b run=%b, expected 1/0001/1", bus.mode_o, bus.led_o, bus.running_o);
      errors++;
    end
    step(4);
    checks++;
    if (bus.led_o !== 4'b0010) begin
      $display("FAIL mode_run_first_step: got led=%b, expected 0010", bus.led_o);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_start_run();
    test_rot_l();
    test_pause_resume();
    test_mode_in_run();
    test_bounce();
    test_tick_mode_collision();
    test_async_reset();
    test_simultaneous_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
